// File: rtl/led_pattern_sequencer_if.sv
// CSR slave bus and PIO write-master bus of the LED pattern sequencer.
// The slave modport is the sequencer's view; the master modport is the CPU/bench view.
interface led_pattern_sequencer_if #(
    parameter int DW = 32
);
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [DW-1:0] m_writedata;

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, m_address, m_chipselect, m_write_n, m_writedata
    );

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, m_address, m_chipselect, m_write_n, m_writedata
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: CSR slave plus a single-beat write master into the LED PIO.
// Plays a pattern table or a rotating pattern at a programmable interval; CPU direct writes are arbitrated in.
module led_pattern_sequencer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DW       = 32,
    parameter int PERIOD_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    led_pattern_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_DWRITE} state_e;

    state_e              state_q, state_d;
    logic                en_q, mode_q, oneshot_q;
    logic [PERIOD_W-1:0] period_q;
    logic [AW:0]         length_q;
    logic                done_q, err_q;
    logic [AW-1:0]       tbl_addr_q;
    logic [DW-1:0]       tbl_q [DEPTH];
    logic [AW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       pattern_q, pattern_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                m_cs_q, m_cs_d;
    logic                m_wn_q, m_wn_d;
    logic [DW-1:0]       m_wd_q, m_wd_d;

    logic          csr_wr, wr_ctrl, wr_period, wr_length, wr_status, wr_taddr, wr_tdata, wr_direct;
    logic          en_csr, clr_en, set_done, set_err, busy, at_last;
    logic [AW:0]   len_eff, last_idx;
    logic [AW-1:0] nidx;
    logic [DW-1:0] rot_pat;
    logic [7:0]    idx8;
    logic [31:0]   rdata;

    assign csr_wr    = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = csr_wr && (bus.address == 3'd0);
    assign wr_period = csr_wr && (bus.address == 3'd1);
    assign wr_length = csr_wr && (bus.address == 3'd2);
    assign wr_status = csr_wr && (bus.address == 3'd3);
    assign wr_taddr  = csr_wr && (bus.address == 3'd4);
    assign wr_tdata  = csr_wr && (bus.address == 3'd5);
    assign wr_direct = csr_wr && (bus.address == 3'd6);

    // A CTRL write in the current cycle stops the run without waiting for the register update.
    assign en_csr = wr_ctrl ? bus.writedata[0] : en_q;
    assign busy   = (state_q != S_IDLE);

    always_comb begin
        len_eff = length_q;
        if (length_q == '0)
            len_eff = (AW+1)'(1);
        else if (length_q > (AW+1)'(DEPTH))
            len_eff = (AW+1)'(DEPTH);
    end

    // >= rather than == so a LENGTH shrunk below the current index still wraps.
    assign last_idx = len_eff - (AW+1)'(1);
    assign at_last  = ({1'b0, idx_q} >= last_idx);
    assign nidx     = at_last ? '0 : idx_q + AW'(1);
    assign rot_pat  = {pattern_q[DW-2:0], pattern_q[DW-1]};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        m_cs_d    = 1'b0;
        m_wn_d    = 1'b1;
        m_wd_d    = m_wd_q;
        clr_en    = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    set_err   = wr_direct;
                    idx_d     = '0;
                    pattern_d = tbl_q[0];
                    m_wd_d    = tbl_q[0];
                    m_cs_d    = 1'b1;
                    m_wn_d    = 1'b0;
                    state_d   = S_WRITE;
                end else if (wr_direct) begin
                    m_wd_d  = DW'(bus.writedata);
                    m_cs_d  = 1'b1;
                    m_wn_d  = 1'b0;
                    state_d = S_DWRITE;
                end
            end
            S_WRITE: begin
                set_err = wr_direct;
                if (!en_csr) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                set_err = wr_direct;
                if (!en_csr) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end else if (mode_q) begin
                    pattern_d = rot_pat;
                    m_wd_d    = rot_pat;
                    m_cs_d    = 1'b1;
                    m_wn_d    = 1'b0;
                    state_d   = S_WRITE;
                end else if (at_last && oneshot_q) begin
                    idx_d    = '0;
                    clr_en   = 1'b1;
                    set_done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    idx_d     = nidx;
                    pattern_d = tbl_q[nidx];
                    m_wd_d    = tbl_q[nidx];
                    m_cs_d    = 1'b1;
                    m_wn_d    = 1'b0;
                    state_d   = S_WRITE;
                end
            end
            S_DWRITE: begin
                set_err = wr_direct;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pattern_q <= '0;
            cnt_q     <= '0;
            m_cs_q    <= 1'b0;
            m_wn_q    <= 1'b1;
            m_wd_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            m_cs_q    <= m_cs_d;
            m_wn_q    <= m_wn_d;
            m_wd_q    <= m_wd_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            oneshot_q  <= 1'b0;
            period_q   <= '0;
            length_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tbl_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q      <= bus.writedata[0];
                mode_q    <= bus.writedata[1];
                oneshot_q <= bus.writedata[2];
            end
            if (clr_en) en_q <= 1'b0;
            if (wr_period) period_q <= PERIOD_W'(bus.writedata);
            if (wr_length) length_q <= bus.writedata[AW:0];
            if (wr_taddr)  tbl_addr_q <= bus.writedata[AW-1:0];
            if (wr_tdata) begin
                tbl_q[tbl_addr_q] <= DW'(bus.writedata);
                tbl_addr_q        <= tbl_addr_q + AW'(1);
            end
            if (set_done)                              done_q <= 1'b1;
            else if (wr_status && bus.writedata[1])    done_q <= 1'b0;
            if (set_err)                               err_q  <= 1'b1;
            else if (wr_status && bus.writedata[2])    err_q  <= 1'b0;
        end
    end

    assign idx8 = 8'(idx_q);

    always_comb begin
        rdata = '0;
        case (bus.address)
            3'd0:    rdata = {29'd0, oneshot_q, mode_q, en_q};
            3'd1:    rdata = 32'(period_q);
            3'd2:    rdata = 32'(length_q);
            3'd3:    rdata = {16'd0, idx8, 5'd0, err_q, done_q, busy};
            3'd4:    rdata = 32'(tbl_addr_q);
            3'd5:    rdata = 32'(tbl_q[tbl_addr_q]);
            default: rdata = '0;
        endcase
    end

    assign bus.readdata     = rdata;
    assign bus.m_address    = 2'd0;
    assign bus.m_chipselect = m_cs_q;
    assign bus.m_write_n    = m_wn_q;
    assign bus.m_writedata  = m_wd_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected PIO writes are queued from a
// high-level model of the playback rules and a monitor pops them on every strobe.
module tb_led_pattern_sequencer;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    led_pattern_sequencer_if #(.DW(DW)) bus_if ();

    led_pattern_sequencer #(.DEPTH(DEPTH), .AW(4), .DW(DW), .PERIOD_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [31:0] tm [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && bus_if.m_chipselect) begin
            chk("strobe_write_n", 32'(bus_if.m_write_n), 32'd0);
            chk("strobe_address", 32'(bus_if.m_address), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=0x%08h required=none", bus_if.m_writedata);
            end else begin
                e = sb.pop_front();
                chk("strobe_data", bus_if.m_writedata, e.data);
                if (e.gap != 0) chk("strobe_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // All bus tasks are entered on a falling edge and return on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic rdchk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        chk(nm, bus_if.readdata, exp);
        bus_if.chipselect = 1'b0;
    endtask

    task automatic load_table();
        wr(3'd4, 32'd0);
        for (int i = 0; i < DEPTH; i++) wr(3'd5, tm[i]);
    endtask

    function automatic int len_eff(input int l);
        return (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : l);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    // Expected PIO writes for n steps of a run: table entries cycle modulo the
    // effective length, or table[0] keeps rotating left; spacing is max(period,1)+1.
    task automatic push_run(input bit rot, input int n, input int per, input int len);
        logic [31:0] p;
        int          le, gap;
        p   = tm[0];
        le  = len_eff(len);
        gap = ((per == 0) ? 1 : per) + 1;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{rot ? p : tm[i % le], (i == 0) ? 0 : gap});
            p = rotl(p);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Clearing EN lands in the WAIT cycle right after the last expected strobe.
    task automatic stop_run();
        wait_drain();
        wr(3'd0, 32'd0);
    endtask

    initial begin : stim
        int len, per, k, le, t;
        bit rot, os;
        bus_if.address = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n = 1'b1;
        bus_if.writedata = '0;
        for (int i = 0; i < DEPTH; i++) tm[i] = '0;

        repeat (3) @(negedge clk);
        chk("in_reset_cs", 32'(bus_if.m_chipselect), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_cs", 32'(bus_if.m_chipselect), 32'd0);
        chk("reset_write_n", 32'(bus_if.m_write_n), 32'd1);
        chk("reset_wdata", bus_if.m_writedata, 32'd0);
        rdchk("reset_status", 3'd3, 32'd0);
        rdchk("reset_ctrl", 3'd0, 32'd0);

        // Table {1,2,4}, LENGTH=3, PERIOD=3: 1,2,4,1 spaced 4 cycles
        tm[0] = 32'd1; tm[1] = 32'd2; tm[2] = 32'd4;
        load_table();
        rdchk("tbl_addr_wrap", 3'd4, 32'd0);
        rdchk("tbl_data_read", 3'd5, 32'd1);
        wr(3'd2, 32'd3);
        wr(3'd1, 32'd3);
        rdchk("length_read", 3'd2, 32'd3);
        rdchk("period_read", 3'd1, 32'd3);
        push_run(1'b0, 4, 3, 3);
        wr(3'd0, 32'd1);
        stop_run();
        rdchk("t1_status_after_stop", 3'd3, 32'd0);

        // Rotate mode, PERIOD=0
        tm[0] = 32'h8000_0001;
        wr(3'd4, 32'd0);
        wr(3'd5, tm[0]);
        wr(3'd1, 32'd0);
        push_run(1'b1, 3, 0, 3);
        wr(3'd0, 32'd3);
        stop_run();
        rdchk("t2_status_after_stop", 3'd3, 32'd0);

        // ONESHOT table mode, LENGTH=2
        wr(3'd2, 32'd2);
        push_run(1'b0, 2, 0, 2);
        wr(3'd0, 32'd5);
        wait_drain();
        repeat (6) @(negedge clk);
        rdchk("oneshot_status", 3'd3, 32'h2);
        rdchk("oneshot_ctrl", 3'd0, 32'h4);
        wr(3'd3, 32'h2);
        rdchk("done_w1c", 3'd3, 32'd0);
        wr(3'd0, 32'd0);

        // DIRECT while idle: one strobe the next cycle
        sb.push_back('{32'h0000_00A5, 0});
        wr(3'd6, 32'h0000_00A5);
        chk("direct_next_cycle_cs", 32'(bus_if.m_chipselect), 32'd1);
        chk("direct_next_cycle_data", bus_if.m_writedata, 32'h0000_00A5);
        @(negedge clk);
        chk("direct_single_cycle", 32'(bus_if.m_chipselect), 32'd0);
        rdchk("direct_reads_zero", 3'd6, 32'd0);
        wr(3'd7, 32'hFFFF_FFFF);
        rdchk("reserved_reads_zero", 3'd7, 32'd0);

        // DIRECT while running is dropped and flags ERR; EN cleared mid-WAIT
        tm[2] = 32'd4;
        wr(3'd2, 32'd3);
        wr(3'd1, 32'd3);
        push_run(1'b0, 2, 3, 3);
        wr(3'd0, 32'd1);
        wait_drain();
        wr(3'd6, 32'h0000_005A);
        wr(3'd0, 32'd0);
        rdchk("err_status", 3'd3, 32'h104);
        wr(3'd3, 32'h4);
        rdchk("err_w1c", 3'd3, 32'h100);

        // Async reset while a strobe is on the bus
        wr(3'd1, 32'd5);
        push_run(1'b0, 1, 5, 3);
        wr(3'd0, 32'd1);
        t = 0;
        while (!bus_if.m_chipselect && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reset_mid_strobe_seen", 32'(bus_if.m_chipselect), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_cs", 32'(bus_if.m_chipselect), 32'd0);
        chk("async_reset_write_n", 32'(bus_if.m_write_n), 32'd1);
        chk("async_reset_wdata", bus_if.m_writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tm[i] = '0;
        @(negedge clk);
        rdchk("post_reset_ctrl", 3'd0, 32'd0);
        rdchk("post_reset_period", 3'd1, 32'd0);
        rdchk("post_reset_tbl", 3'd5, 32'd0);
        chk("post_reset_queue", 32'(sb.size()), 32'd0);

        // Randomized runs against the model
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < DEPTH; i++) tm[i] = $urandom;
            load_table();
            rdchk("rnd_tbl_read", 3'd5, tm[0]);
            len = $urandom_range(0, 19);
            per = $urandom_range(0, 4);
            rot = 1'($urandom_range(0, 1));
            os  = !rot && ($urandom_range(0, 2) == 0);
            le  = len_eff(len);
            wr(3'd2, 32'(len));
            wr(3'd1, 32'(per));
            rdchk("rnd_length_read", 3'd2, 32'(len));
            if (os) begin
                push_run(1'b0, le, per, len);
                wr(3'd0, 32'd5);
                wait_drain();
                repeat (2 * (per + 2) + 4) @(negedge clk);
                rdchk("rnd_oneshot_status", 3'd3, 32'h2);
                rdchk("rnd_oneshot_ctrl", 3'd0, 32'h4);
                wr(3'd3, 32'h2);
                wr(3'd0, 32'd0);
            end else begin
                k = $urandom_range(1, le + 3);
                push_run(rot, k, per, len);
                wr(3'd0, rot ? 32'd3 : 32'd1);
                stop_run();
                rdchk("rnd_status_after_stop", 3'd3, 32'(rot ? 0 : ((k - 1) % le)) << 8);
            end
        end

        repeat (8) @(negedge clk);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
